// File: rtl/cac_pkg.sv
// Shared definitions for the two-lane combine-and-compare (CaC) unit.
//   CAC_DATA_W  : default width of destination IDs and update values
//   OP_SUM/OP_MIN : combine-operator selectors
//   cac_entry_t : one update {valid, dest, update}
//   cac_combine : merges two update values with the selected operator
package cac_pkg;

    localparam int CAC_DATA_W = 32;

    localparam int OP_SUM = 0;
    localparam int OP_MIN = 1;

    typedef struct packed {
        logic                  valid;
        logic [CAC_DATA_W-1:0] dest;
        logic [CAC_DATA_W-1:0] update;
    } cac_entry_t;

    // Unsigned minimum, or a sum that wraps modulo 2^CAC_DATA_W.
    function automatic logic [CAC_DATA_W-1:0] cac_combine(
        input logic                  op_min,
        input logic [CAC_DATA_W-1:0] x,
        input logic [CAC_DATA_W-1:0] y
    );
        if (op_min) begin
            return (x < y) ? x : y;
        end
        return x + y;
    endfunction

endpackage

// File: rtl/cac_compare_combine.sv
// Combinational compare/combine of one lane pair.
// Ports:
//   a_in, b_in   : lane A / lane B entries from the previous stage
//   a_out, b_out : ordered / merged entries; lane A always carries the
//                  smaller destination or the single surviving entry
module cac_compare_combine
    import cac_pkg::*;
#(
    parameter int COMBINE_MIN = OP_MIN
) (
    input  cac_entry_t a_in,
    input  cac_entry_t b_in,
    output cac_entry_t a_out,
    output cac_entry_t b_out
);

    logic [CAC_DATA_W-1:0] merged_update;

    always_comb begin
        merged_update = cac_combine(COMBINE_MIN != 0, a_in.update, b_in.update);

        a_out = a_in;
        b_out = b_in;

        if (!a_in.valid && !b_in.valid) begin
            // Both idle: data fields travel untouched.
            a_out = a_in;
            b_out = b_in;
        end else if (a_in.valid && !b_in.valid) begin
            a_out = a_in;
            b_out = '0;
        end else if (!a_in.valid && b_in.valid) begin
            // Compact the lone valid entry into lane A.
            a_out = b_in;
            b_out = '0;
        end else if (a_in.dest == b_in.dest) begin
            a_out.valid  = 1'b1;
            a_out.dest   = a_in.dest;
            a_out.update = merged_update;
            b_out        = '0;
        end else if (a_in.dest > b_in.dest) begin
            a_out = b_in;
            b_out = a_in;
        end
    end

endmodule

// File: rtl/test_for_cac.sv
// Two-lane combine-and-compare pipeline.
// Stage 0 registers the raw lanes, stage 1 registers the compare/combine
// result, stages 2..PIPE_DEPTH-1 are plain delay. Fixed latency, no stall.
// Ports:
//   clk, rst (synchronous, active-low)
//   InputValid_*/InDestVid_*/InUpdate_* : lane A/B inputs
//   OutValid_*/OutDestVid_*/OutUpdate_* : last-stage registers
//   Valid_reg_*, DestVid_reg_*, Update_reg_* {A,B}{0,1,2} : stage debug taps
module test_for_cac
    import cac_pkg::*;
#(
    parameter int DATA_W      = CAC_DATA_W,
    parameter int PIPE_DEPTH  = 3,
    parameter int COMBINE_MIN = OP_MIN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              InputValid_A,
    input  logic              InputValid_B,
    input  logic [DATA_W-1:0] InDestVid_A,
    input  logic [DATA_W-1:0] InDestVid_B,
    input  logic [DATA_W-1:0] InUpdate_A,
    input  logic [DATA_W-1:0] InUpdate_B,
    output logic              OutValid_A,
    output logic              OutValid_B,
    output logic [DATA_W-1:0] OutDestVid_A,
    output logic [DATA_W-1:0] OutDestVid_B,
    output logic [DATA_W-1:0] OutUpdate_A,
    output logic [DATA_W-1:0] OutUpdate_B,
    output logic              Valid_reg_A0,
    output logic              Valid_reg_A1,
    output logic              Valid_reg_A2,
    output logic              Valid_reg_B0,
    output logic              Valid_reg_B1,
    output logic              Valid_reg_B2,
    output logic [DATA_W-1:0] DestVid_reg_A0,
    output logic [DATA_W-1:0] DestVid_reg_A1,
    output logic [DATA_W-1:0] DestVid_reg_A2,
    output logic [DATA_W-1:0] DestVid_reg_B0,
    output logic [DATA_W-1:0] DestVid_reg_B1,
    output logic [DATA_W-1:0] DestVid_reg_B2,
    output logic [DATA_W-1:0] Update_reg_A0,
    output logic [DATA_W-1:0] Update_reg_A1,
    output logic [DATA_W-1:0] Update_reg_A2,
    output logic [DATA_W-1:0] Update_reg_B0,
    output logic [DATA_W-1:0] Update_reg_B1,
    output logic [DATA_W-1:0] Update_reg_B2
);

    // The entry struct is sized by the package, so the port width must agree.
    generate
        if (PIPE_DEPTH < 3) begin : g_depth_check
            $error("test_for_cac: PIPE_DEPTH must be at least 3");
        end
        if (DATA_W != CAC_DATA_W) begin : g_width_check
            $error("test_for_cac: DATA_W must equal cac_pkg::CAC_DATA_W");
        end
    endgenerate

    cac_entry_t in_a;
    cac_entry_t in_b;
    cac_entry_t cmb_a;
    cac_entry_t cmb_b;

    cac_entry_t a_pipe_reg  [PIPE_DEPTH];
    cac_entry_t b_pipe_reg  [PIPE_DEPTH];
    cac_entry_t a_pipe_next [PIPE_DEPTH];
    cac_entry_t b_pipe_next [PIPE_DEPTH];

    assign in_a = {InputValid_A, InDestVid_A, InUpdate_A};
    assign in_b = {InputValid_B, InDestVid_B, InUpdate_B};

    cac_compare_combine #(
        .COMBINE_MIN (COMBINE_MIN)
    ) u_cc (
        .a_in  (a_pipe_reg[0]),
        .b_in  (b_pipe_reg[0]),
        .a_out (cmb_a),
        .b_out (cmb_b)
    );

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_raw
                assign a_pipe_next[gi] = in_a;
                assign b_pipe_next[gi] = in_b;
            end else if (gi == 1) begin : g_cmb
                assign a_pipe_next[gi] = cmb_a;
                assign b_pipe_next[gi] = cmb_b;
            end else begin : g_dly
                assign a_pipe_next[gi] = a_pipe_reg[gi-1];
                assign b_pipe_next[gi] = b_pipe_reg[gi-1];
            end

            // Reset clears every stage, so in-flight pairs are simply dropped.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    a_pipe_reg[gi] <= '0;
                    b_pipe_reg[gi] <= '0;
                end else begin
                    a_pipe_reg[gi] <= a_pipe_next[gi];
                    b_pipe_reg[gi] <= b_pipe_next[gi];
                end
            end
        end
    endgenerate

    assign OutValid_A     = a_pipe_reg[PIPE_DEPTH-1].valid;
    assign OutDestVid_A   = a_pipe_reg[PIPE_DEPTH-1].dest;
    assign OutUpdate_A    = a_pipe_reg[PIPE_DEPTH-1].update;
    assign OutValid_B     = b_pipe_reg[PIPE_DEPTH-1].valid;
    assign OutDestVid_B   = b_pipe_reg[PIPE_DEPTH-1].dest;
    assign OutUpdate_B    = b_pipe_reg[PIPE_DEPTH-1].update;

    assign Valid_reg_A0   = a_pipe_reg[0].valid;
    assign DestVid_reg_A0 = a_pipe_reg[0].dest;
    assign Update_reg_A0  = a_pipe_reg[0].update;
    assign Valid_reg_B0   = b_pipe_reg[0].valid;
    assign DestVid_reg_B0 = b_pipe_reg[0].dest;
    assign Update_reg_B0  = b_pipe_reg[0].update;

    assign Valid_reg_A1   = a_pipe_reg[1].valid;
    assign DestVid_reg_A1 = a_pipe_reg[1].dest;
    assign Update_reg_A1  = a_pipe_reg[1].update;
    assign Valid_reg_B1   = b_pipe_reg[1].valid;
    assign DestVid_reg_B1 = b_pipe_reg[1].dest;
    assign Update_reg_B1  = b_pipe_reg[1].update;

    assign Valid_reg_A2   = a_pipe_reg[2].valid;
    assign DestVid_reg_A2 = a_pipe_reg[2].dest;
    assign Update_reg_A2  = a_pipe_reg[2].update;
    assign Valid_reg_B2   = b_pipe_reg[2].valid;
    assign DestVid_reg_B2 = b_pipe_reg[2].dest;
    assign Update_reg_B2  = b_pipe_reg[2].update;

endmodule

// File: tb/tb_test_for_cac.sv
// Scoreboard bench for test_for_cac: one instance with min combine, one with
// sum combine, driven by the same directed lane pairs.
module tb_test_for_cac;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic [31:0] u;
    } ent_t;

    typedef struct {
        int   sel;   // 0 stage0, 1 stage1, 2 stage2, 3 out(min), 4 out(sum)
        int   due;
        ent_t a;
        ent_t b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        va = 1'b0, vb = 1'b0;
    logic [31:0] da = '0, db = '0, ua = '0, ub = '0;

    // min-combine instance
    logic        m_ova, m_ovb;
    logic [31:0] m_oda, m_odb, m_oua, m_oub;
    logic        m_va0, m_va1, m_va2, m_vb0, m_vb1, m_vb2;
    logic [31:0] m_da0, m_da1, m_da2, m_db0, m_db1, m_db2;
    logic [31:0] m_ua0, m_ua1, m_ua2, m_ub0, m_ub1, m_ub2;
    // sum-combine instance
    logic        s_ova, s_ovb;
    logic [31:0] s_oda, s_odb, s_oua, s_oub;
    logic        s_va0, s_va1, s_va2, s_vb0, s_vb1, s_vb2;
    logic [31:0] s_da0, s_da1, s_da2, s_db0, s_db1, s_db2;
    logic [31:0] s_ua0, s_ua1, s_ua2, s_ub0, s_ub1, s_ub2;

    test_for_cac #(.DATA_W(32), .PIPE_DEPTH(3), .COMBINE_MIN(1)) dut_min (
        .clk(clk), .rst(rst),
        .InputValid_A(va), .InputValid_B(vb),
        .InDestVid_A(da), .InDestVid_B(db),
        .InUpdate_A(ua), .InUpdate_B(ub),
        .OutValid_A(m_ova), .OutValid_B(m_ovb),
        .OutDestVid_A(m_oda), .OutDestVid_B(m_odb),
        .OutUpdate_A(m_oua), .OutUpdate_B(m_oub),
        .Valid_reg_A0(m_va0), .Valid_reg_A1(m_va1), .Valid_reg_A2(m_va2),
        .Valid_reg_B0(m_vb0), .Valid_reg_B1(m_vb1), .Valid_reg_B2(m_vb2),
        .DestVid_reg_A0(m_da0), .DestVid_reg_A1(m_da1), .DestVid_reg_A2(m_da2),
        .DestVid_reg_B0(m_db0), .DestVid_reg_B1(m_db1), .DestVid_reg_B2(m_db2),
        .Update_reg_A0(m_ua0), .Update_reg_A1(m_ua1), .Update_reg_A2(m_ua2),
        .Update_reg_B0(m_ub0), .Update_reg_B1(m_ub1), .Update_reg_B2(m_ub2)
    );

    test_for_cac #(.DATA_W(32), .PIPE_DEPTH(3), .COMBINE_MIN(0)) dut_sum (
        .clk(clk), .rst(rst),
        .InputValid_A(va), .InputValid_B(vb),
        .InDestVid_A(da), .InDestVid_B(db),
        .InUpdate_A(ua), .InUpdate_B(ub),
        .OutValid_A(s_ova), .OutValid_B(s_ovb),
        .OutDestVid_A(s_oda), .OutDestVid_B(s_odb),
        .OutUpdate_A(s_oua), .OutUpdate_B(s_oub),
        .Valid_reg_A0(s_va0), .Valid_reg_A1(s_va1), .Valid_reg_A2(s_va2),
        .Valid_reg_B0(s_vb0), .Valid_reg_B1(s_vb1), .Valid_reg_B2(s_vb2),
        .DestVid_reg_A0(s_da0), .DestVid_reg_A1(s_da1), .DestVid_reg_A2(s_da2),
        .DestVid_reg_B0(s_db0), .DestVid_reg_B1(s_db1), .DestVid_reg_B2(s_db2),
        .Update_reg_A0(s_ua0), .Update_reg_A1(s_ua1), .Update_reg_A2(s_ua2),
        .Update_reg_B0(s_ub0), .Update_reg_B1(s_ub1), .Update_reg_B2(s_ub2)
    );

    always #5 clk = ~clk;

    int   edge_cnt = 0;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always @(posedge clk) edge_cnt++;

    function automatic ent_t e(input logic v, input logic [31:0] d, input logic [31:0] u);
        return {v, d, u};
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            0: return "stage0";
            1: return "stage1";
            2: return "stage2";
            3: return "out_min";
            default: return "out_sum";
        endcase
    endfunction

    // Monitor: compares every expectation that falls due at this edge count.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].due == edge_cnt) begin
                ent_t ga, gb;
                case (exp_q[i].sel)
                    0: begin ga = {m_va0, m_da0, m_ua0}; gb = {m_vb0, m_db0, m_ub0}; end
                    1: begin ga = {m_va1, m_da1, m_ua1}; gb = {m_vb1, m_db1, m_ub1}; end
                    2: begin ga = {m_va2, m_da2, m_ua2}; gb = {m_vb2, m_db2, m_ub2}; end
                    3: begin ga = {m_ova, m_oda, m_oua}; gb = {m_ovb, m_odb, m_oub}; end
                    default: begin ga = {s_ova, s_oda, s_oua}; gb = {s_ovb, s_odb, s_oub}; end
                endcase
                checks++;
                if (ga !== exp_q[i].a || gb !== exp_q[i].b) begin
                    failures++;
                    $display("FAIL %s edge=%0d got A=(%0b,%0d,%h) B=(%0b,%0d,%h) want A=(%0b,%0d,%h) B=(%0b,%0d,%h)",
                             sel_name(exp_q[i].sel), edge_cnt,
                             ga.v, ga.d, ga.u, gb.v, gb.d, gb.u,
                             exp_q[i].a.v, exp_q[i].a.d, exp_q[i].a.u,
                             exp_q[i].b.v, exp_q[i].b.d, exp_q[i].b.u);
                end else begin
                    $display("check %s edge=%0d ok A=(%0b,%0d,%h) B=(%0b,%0d,%h)",
                             sel_name(exp_q[i].sel), edge_cnt,
                             ga.v, ga.d, ga.u, gb.v, gb.d, gb.u);
                end
                exp_q.delete(i);
            end
        end
    end

    function automatic void push(input int sel, input int due, input ent_t a, input ent_t b);
        exp_t it;
        it.sel = sel;
        it.due = due;
        it.a   = a;
        it.b   = b;
        exp_q.push_back(it);
    endfunction

    // Drive one pair; ma/mb = expected min-combine result, sa/sb = sum result.
    task automatic drive(input ent_t a, input ent_t b, input ent_t ma, input ent_t mb,
                         input ent_t sa, input ent_t sb);
        @(negedge clk);
        #1;
        rst = 1'b1;
        va = a.v; da = a.d; ua = a.u;
        vb = b.v; db = b.d; ub = b.u;
        push(0, edge_cnt + 1, a, b);
        push(1, edge_cnt + 2, ma, mb);
        push(2, edge_cnt + 3, ma, mb);
        push(3, edge_cnt + 3, ma, mb);
        push(4, edge_cnt + 3, sa, sb);
    endtask

    // Hold reset for one edge; everything in flight is discarded.
    task automatic reset_cycle();
        @(negedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        for (int s = 0; s < 5; s++) push(s, edge_cnt + 1, '0, '0);
    endtask

    ent_t z;
    initial begin
        z = '0;
        repeat (3) reset_cycle();

        // equal dest: min=5, sum=12; held for several cycles
        repeat (4) drive(e(1,120,7), e(1,120,5), e(1,120,5), z, e(1,120,12), z);
        // equal dest with wrapping sum
        drive(e(1,9,32'hFFFF_FFFF), e(1,9,2), e(1,9,2), z, e(1,9,1), z);
        // swap
        drive(e(1,200,3), e(1,50,4), e(1,50,4), e(1,200,3), e(1,50,4), e(1,200,3));
        // already ordered
        drive(e(1,50,4), e(1,200,3), e(1,50,4), e(1,200,3), e(1,50,4), e(1,200,3));
        // only B valid
        drive(e(0,7,1), e(1,30,9), e(1,30,9), z, e(1,30,9), z);
        // both invalid: data passes through
        drive(e(0,11,22), e(0,33,44), e(0,11,22), e(0,33,44), e(0,11,22), e(0,33,44));
        // only A valid
        drive(e(1,5,6), e(0,8,9), e(1,5,6), z, e(1,5,6), z);
        // equal dest, min picks A
        drive(e(1,77,3), e(1,77,10), e(1,77,3), z, e(1,77,13), z);
        // swap with equal updates
        drive(e(1,1000,8), e(1,999,8), e(1,999,8), e(1,1000,8), e(1,999,8), e(1,1000,8));

        // stream then reset mid-flight
        drive(e(1,40,1), e(1,20,2), e(1,20,2), e(1,40,1), e(1,20,2), e(1,40,1));
        drive(e(1,60,5), e(1,60,6), e(1,60,5), z, e(1,60,11), z);
        reset_cycle();
        drive(e(1,3,4), e(1,2,5), e(1,2,5), e(1,3,4), e(1,2,5), e(1,3,4));
        drive(e(0,0,0), e(1,15,16), e(1,15,16), z, e(1,15,16), z);
        drive(e(1,21,32'h8000_0000), e(1,21,32'h8000_0001),
              e(1,21,32'h8000_0000), z, e(1,21,32'h0000_0001), z);

        // bounded drain of the scoreboard
        for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/test_for_cac.md
# test_for_cac

Two-lane combine-and-compare (CaC) unit for the update-merging network of the algorithm processing core. Each cycle it accepts one update per lane (A, B), each a destination vertex ID plus an update value. It orders the pair by destination ID and merges two valid updates to the same vertex into one. The pipeline is fixed-latency with no backpressure, and every stage is exposed on debug ports.

## Interface
Parameters:
- DATA_W, 32, width of destination vertex IDs and update values.
- PIPE_DEPTH, 3, number of register stages. Must be ≥3; elaboration fails otherwise.
- COMBINE_MIN, 1, combine operator: 1 = unsigned minimum (SSSP/BFS), 0 = sum modulo 2^DATA_W (PageRank).

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- clk  in  1  clock, all state changes on the rising edge.
- rst  in  1  synchronous active-low reset.
- InputValid_A / InputValid_B  in  1  lane input valid.
- InDestVid_A / InDestVid_B  in  DATA_W  lane destination vertex ID.
- InUpdate_A / InUpdate_B  in  DATA_W  lane update value.
- OutValid_A / OutValid_B  out  1  final-stage valid.
- OutDestVid_A / OutDestVid_B  out  DATA_W  final-stage destination ID.
- OutUpdate_A / OutUpdate_B  out  DATA_W  final-stage update value.
- Valid_reg_{A,B}{0,1,2}  out  1  stage 0/1/2 valid registers.
- DestVid_reg_{A,B}{0,1,2}  out  DATA_W  stage 0/1/2 destination-ID registers.
- Update_reg_{A,B}{0,1,2}  out  DATA_W  stage 0/1/2 update registers.

## Operation
- **Stage 0** registers the raw lane inputs unchanged.
- **Stage 1** registers the compare/combine result computed from stage 0 (vA/dA/uA and vB/dB/uB). Exactly one rule applies, in this order:
  - vA=vB=0: both lanes pass through unchanged, valids 0.
  - Exactly one lane valid: the valid entry goes to lane A. Lane B gets valid 0, dest 0, update 0.
  - Both valid, dA==dB: lane A gets valid 1, dest dA, update = combine(uA,uB). Lane B gets valid 0, dest 0, update 0.
  - Both valid, dA<dB (unsigned): pass through.
  - Both valid, dA>dB: swap the lanes, so lane A always holds the smaller destination ID.
- **Stages 2..PIPE_DEPTH-1** are pure delay registers.
- **Outputs:** Out* are the last stage's registers. The stage-2 debug ports equal Out* when PIPE_DEPTH=3.
- **Combine arithmetic:** min is an unsigned compare. The sum is DATA_W bits wide and wraps with no saturation and no carry out.
- **Throughput:** one lane pair per cycle, unconditionally. There is no ready/stall.
- **Data under invalid:** data fields of invalid entries are don't-care for downstream consumers. They still follow the rules above, so the bench can check them exactly.

## Timing
- **Reset:** while rst=0 at a rising edge, every stage register goes to 0: all valids, DestVid and Update. All outputs therefore read 0 after reset.
- **Reset mid-operation:** in-flight entries are discarded, with no partial flush.
- **Latency:** inputs sampled at edge N appear in stage 0 after edge N. They appear in stage 1 (combined) after N+1 and on Out* after N+PIPE_DEPTH-1. That is PIPE_DEPTH register stages.
- **Inputs:** unknown inputs sampled while out of reset are not required to be handled. The bench drives defined values from the first post-reset edge.
- **Independence of pairs:** consecutive pairs are independent. There is no merging across cycles.

## Structure
- **Shared package (cac_pkg):**
  - DATA_W default.
  - Packed struct cac_entry_t {valid, dest[DATA_W], update[DATA_W]}.
  - Combine-operator localparams.
- **Sub-module cac_compare_combine:** a purely combinational block that takes two cac_entry_t and produces two cac_entry_t, implementing the stage-1 rules. The top is a generate-loop array of cac_entry_t pipeline registers around it, plus the debug-port wiring.

## Test plan
- **Equal dest, min combine:** reset 3 cycles, then hold A=(1,120,7), B=(1,120,5).
  - After 3 edges: OutValid_A=1, OutDestVid_A=120, OutUpdate_A=5, OutValid_B=0, OutDestVid_B=0, OutUpdate_B=0.
  - The output holds while the input is held.
- **Same stimulus with COMBINE_MIN=0:** OutUpdate_A=12. Also A=(1,9,0xFFFFFFFF), B=(1,9,2) gives OutUpdate_A=1 (wrap).
- **Swap and passthrough:**
  - A=(1,200,3), B=(1,50,4) gives A=(1,50,4), B=(1,200,3).
  - A=(1,50,4), B=(1,200,3) is unchanged.
- **Single valid:**
  - A=(0,7,1), B=(1,30,9) gives A=(1,30,9), B=(0,0,0).
  - Both invalid gives both valids 0.
- **Streaming and latency:** apply a distinct pair every cycle for 8 cycles. Each result appears on Out* exactly 2 edges after appearing in stage 0, with stage 1 matching the combine rules one edge after stage 0.
- **Mid-stream reset:** assert rst=0 for one edge during streaming. The next cycle all debug and output ports are 0, and post-reset pairs emerge with normal latency.
